// File: rtl/samplerz_pkg.sv
// Shared constants for the SamplerZ base sampler: table geometry, the Falcon RCDT
// table and the sampler FSM state type.
package samplerz_pkg;

    localparam int TABLE_LEN = 18;
    localparam int RND_W     = 72;
    localparam int Z_W       = 5;
    localparam int IDX_W     = $clog2(TABLE_LEN);

    // Falcon reverse cumulative distribution table, strictly descending.
    localparam logic [RND_W-1:0] RCDT [TABLE_LEN] = '{
        72'd3024686241123004913666,
        72'd1564742784480091954050,
        72'd636254429462080897535,
        72'd199560484645026482916,
        72'd47667343854657281903,
        72'd8595902006365044063,
        72'd1163297957344668388,
        72'd117656387352093658,
        72'd8867391802663976,
        72'd496969357462633,
        72'd20680885154299,
        72'd638331848991,
        72'd14602316184,
        72'd247426747,
        72'd3104126,
        72'd28824,
        72'd198,
        72'd1
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/base_sampler_cdt_if.sv
// Request/result bundle of the base sampler; stat_cnt exists only when
// BASE_SAMPLER_STATS_EN is defined.
interface base_sampler_cdt_if;
    import samplerz_pkg::*;

    logic             start;
    logic [RND_W-1:0] rnd_l;
    logic [RND_W-1:0] rnd_r;
    logic             busy;
    logic             done;
    logic             z0_valid;
    logic [Z_W-1:0]   z0_l;
    logic [Z_W-1:0]   z0_r;
`ifdef BASE_SAMPLER_STATS_EN
    logic [31:0]      stat_cnt;

    modport master (output start, rnd_l, rnd_r,
                    input  busy, done, z0_valid, z0_l, z0_r, stat_cnt);
    modport slave  (input  start, rnd_l, rnd_r,
                    output busy, done, z0_valid, z0_l, z0_r, stat_cnt);
`else
    modport master (output start, rnd_l, rnd_r,
                    input  busy, done, z0_valid, z0_l, z0_r);
    modport slave  (input  start, rnd_l, rnd_r,
                    output busy, done, z0_valid, z0_l, z0_r);
`endif

endinterface

// File: rtl/cdt_cmp_lane.sv
// One sampler lane: holds its random word and counts table entries above it,
// comparing against one entry per cycle.
module cdt_cmp_lane
    import samplerz_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [RND_W-1:0] rnd_i,
    input  logic [RND_W-1:0] entry_i,
    output logic [Z_W-1:0]   acc_d_o
);

    logic [RND_W-1:0] rnd_q;
    logic [Z_W-1:0]   acc_q;
    logic             gt;

    // Comparator runs every cycle regardless of state so activity is data independent.
    assign gt      = (rnd_q < entry_i);
    assign acc_d_o = acc_q + {{(Z_W-1){1'b0}}, gt};

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_q <= '0;
            acc_q <= '0;
        end else if (load_i) begin
            rnd_q <= rnd_i;
            acc_q <= '0;
        end else if (step_i) begin
            acc_q <= acc_d_o;
        end
    end

endmodule

// File: rtl/base_sampler_cdt.sv
// Constant-time bimodal CDT base sampler: both lanes walk all TABLE_LEN entries.
// Optional BASE_SAMPLER_STATS_EN adds a saturating completed-pair counter.
module base_sampler_cdt
    import samplerz_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    base_sampler_cdt_if.slave  bus
);

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             busy_q;
    logic             done_q;
    logic             valid_q;
    logic [Z_W-1:0]   z0_l_q;
    logic [Z_W-1:0]   z0_r_q;
    logic [Z_W-1:0]   acc_l_d;
    logic [Z_W-1:0]   acc_r_d;
    logic             accept;
    logic             step;
    logic             last;
    logic [RND_W-1:0] entry;

    assign accept = bus.start && (state_q != RUN);
    assign step   = (state_q == RUN);
    assign last   = step && (idx_q == IDX_W'(TABLE_LEN - 1));
    assign entry  = RCDT[idx_q];

    cdt_cmp_lane u_lane_l (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (accept),
        .step_i  (step),
        .rnd_i   (bus.rnd_l),
        .entry_i (entry),
        .acc_d_o (acc_l_d)
    );

    cdt_cmp_lane u_lane_r (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (accept),
        .step_i  (step),
        .rnd_i   (bus.rnd_r),
        .entry_i (entry),
        .acc_d_o (acc_r_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            z0_l_q  <= '0;
            z0_r_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (last) begin
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        valid_q <= 1'b1;
                        z0_l_q  <= acc_l_d;
                        z0_r_q  <= acc_r_d;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new pair; results hold until then.
                    if (bus.start) begin
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                        state_q <= RUN;
                    end
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.z0_valid = valid_q;
    assign bus.z0_l     = z0_l_q;
    assign bus.z0_r     = z0_r_q;

`ifdef BASE_SAMPLER_STATS_EN
    logic [31:0] stat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else if (done_q && (stat_q != 32'hFFFF_FFFF)) begin
            stat_q <= stat_q + 32'd1;
        end
    end

    assign bus.stat_cnt = stat_q;
`endif

endmodule

// File: tb/tb_base_sampler_cdt.sv
// Directed-vector bench for base_sampler_cdt; expected z0 values are hand-counted
// against the Falcon RCDT table.
module tb_base_sampler_cdt;
    import samplerz_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   lat;
    int   n_done;

    localparam logic [RND_W-1:0] ONES = {RND_W{1'b1}};

    base_sampler_cdt_if bus ();

    base_sampler_cdt dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a posedge with the sampler not in RUN. Accepts a pair,
    // optionally pulses start again mid-run with junk data, and returns the number
    // of edges from the accept edge to the edge that raised done (-1 on timeout).
    task automatic run_pair(input logic [RND_W-1:0] rl, input logic [RND_W-1:0] rr,
                            input bit mid_start, output int edges);
        bus.start = 1'b1;
        bus.rnd_l = rl;
        bus.rnd_r = rr;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.rnd_l = ONES;
        bus.rnd_r = '0;
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        edges = -1;
        for (int i = 1; i <= 40; i++) begin
            bus.start = mid_start && (i == 6);
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done) begin
                edges = i;
                break;
            end
        end
        if (edges < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    always @(posedge clk) if (rst_n && bus.done) n_done++;

    initial begin
        n_vec = 0;
        n_err = 0;
        n_done = 0;
        bus.start = 1'b0;
        bus.rnd_l = '0;
        bus.rnd_r = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_valid", 32'(bus.z0_valid), 32'd0);
        check("rst_z0_l", 32'(bus.z0_l), 32'd0);
        check("rst_z0_r", 32'(bus.z0_r), 32'd0);

        // Extremes: zero counts every entry, all-ones counts none.
        run_pair('0, ONES, 1'b0, lat);
        check("ext_latency", 32'(lat), 32'd18);
        check("ext_z0_l", 32'(bus.z0_l), 32'd18);
        check("ext_z0_r", 32'(bus.z0_r), 32'd0);
        check("ext_valid", 32'(bus.z0_valid), 32'd1);
        check("ext_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        check("ext_done_pulse", 32'(bus.done), 32'd0);
        check("ext_valid_hold", 32'(bus.z0_valid), 32'd1);
        check("ext_z0_l_hold", 32'(bus.z0_l), 32'd18);

        run_pair(RCDT[0], RCDT[0] - 72'd1, 1'b0, lat);
        check("top_z0_l", 32'(bus.z0_l), 32'd0);
        check("top_z0_r", 32'(bus.z0_r), 32'd1);

        run_pair(RCDT[17], RCDT[17] - 72'd1, 1'b0, lat);
        check("bot_z0_l", 32'(bus.z0_l), 32'd17);
        check("bot_z0_r", 32'(bus.z0_r), 32'd18);

        run_pair(RCDT[5], 72'd1000000000000, 1'b0, lat);
        check("mid_z0_l", 32'(bus.z0_l), 32'd5);
        check("mid_z0_r", 32'(bus.z0_r), 32'd11);

        // start pulsed during RUN must not disturb the running pair.
        run_pair('0, ONES, 1'b1, lat);
        check("ign_latency", 32'(lat), 32'd18);
        check("ign_z0_l", 32'(bus.z0_l), 32'd18);
        check("ign_z0_r", 32'(bus.z0_r), 32'd0);
        @(posedge clk);
        #1;
        check("ign_no_restart", 32'(bus.busy), 32'd0);

        // Back-to-back: second start issued in the done cycle.
        run_pair(RCDT[0], '0, 1'b0, lat);
        check("b2b_a_z0_l", 32'(bus.z0_l), 32'd0);
        check("b2b_a_z0_r", 32'(bus.z0_r), 32'd18);
        check("b2b_a_done", 32'(bus.done), 32'd1);
        bus.start = 1'b1;
        bus.rnd_l = 72'd200;
        bus.rnd_r = 72'd197;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b_valid_drop", 32'(bus.z0_valid), 32'd0);
        check("b2b_busy", 32'(bus.busy), 32'd1);
        check("b2b_z0_l_kept", 32'(bus.z0_l), 32'd0);
        check("b2b_z0_r_kept", 32'(bus.z0_r), 32'd18);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        check("b2b_latency", 32'(lat), 32'd18);
        check("b2b_z0_l", 32'(bus.z0_l), 32'd16);
        check("b2b_z0_r", 32'(bus.z0_r), 32'd17);

        // Reset while RUN is at index 9.
        bus.start = 1'b1;
        bus.rnd_l = '0;
        bus.rnd_r = '0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        n_done = 0;
        rst_n = 1'b0;
        #1;
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_valid", 32'(bus.z0_valid), 32'd0);
        check("mrst_z0_l", 32'(bus.z0_l), 32'd0);
        check("mrst_z0_r", 32'(bus.z0_r), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("mrst_no_done", 32'(n_done), 32'd0);
        check("mrst_idle", 32'(bus.busy), 32'd0);

`ifdef BASE_SAMPLER_STATS_EN
        check("stat_rst", bus.stat_cnt, 32'd0);
        for (int p = 0; p < 3; p++) run_pair(72'd5, 72'd6, 1'b0, lat);
        @(posedge clk);
        #1;
        check("stat_three", bus.stat_cnt, 32'd3);
        force dut.stat_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.stat_q;
        run_pair(72'd5, 72'd6, 1'b0, lat);
        @(posedge clk);
        #1;
        check("stat_saturate", bus.stat_cnt, 32'hFFFF_FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
